// File: rtl/coefficient_bank_streamer.sv
// Multi-bank, run-time-writable coefficient store. Streams one selected bank,
// forward or reversed, over a valid/ready handshake into a FIR coefficient port.
module coefficient_bank_streamer #(
  parameter int LENGTH     = 20,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int BANK_WIDTH = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wrEnable,
  input  logic [BANK_WIDTH-1:0]        wrBank,
  input  logic [ADDR_WIDTH-1:0]        wrAddr,
  input  logic signed [DATA_WIDTH-1:0] wrData,
  input  logic                         startLoad,
  input  logic [BANK_WIDTH-1:0]        bankSelect,
  input  logic                         reverseOrder,
  input  logic                         coefficientReady,
  output logic signed [DATA_WIDTH-1:0] coefficientOut,
  output logic                         coefficientValid,
  output logic                         busy,
  output logic                         loadDone,
  output logic                         filterSetFlag,
  output logic                         errorFlag
);

  localparam int                    BANK_SLOTS  = 1 << BANK_WIDTH;
  localparam logic [BANK_WIDTH:0]   NUM_BANKS_W = (BANK_WIDTH+1)'(NUM_BANKS);
  localparam logic [ADDR_WIDTH:0]   LENGTH_W    = (ADDR_WIDTH+1)'(LENGTH);
  localparam logic [ADDR_WIDTH:0]   LAST_COUNT  = (ADDR_WIDTH+1)'(LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX    = ADDR_WIDTH'(LENGTH - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  function automatic logic signed [DATA_WIDTH-1:0] default_coef(input int bank, input int idx);
    int v;
    v = 0;
    if (bank == 0) begin
      case (idx)
        0: v = 34;    1: v = 34;    2: v = 0;     3: v = 49;    4: v = 125;
        5: v = -77;   6: v = -51;   7: v = 8;     8: v = 98;    9: v = 109;
        10: v = -91;  11: v = -3;   12: v = 9;    13: v = 1;    14: v = 59;
        15: v = 75;   16: v = 19;   17: v = 58;   18: v = -97;  19: v = 10;
        default: v = 0;
      endcase
    end
    return DATA_WIDTH'(v);
  endfunction

  state_t                       state_reg;
  logic [BANK_WIDTH-1:0]        bank_reg;
  logic                         rev_reg;
  logic [ADDR_WIDTH-1:0]        idx_reg;
  logic [ADDR_WIDTH:0]          count_reg;
  logic signed [DATA_WIDTH-1:0] mem_word [BANK_SLOTS][LENGTH];

  logic                         wr_reject;
  logic                         wr_accept;
  logic                         start_accept;
  logic                         start_reject;
  logic [ADDR_WIDTH-1:0]        start_idx;
  logic [ADDR_WIDTH-1:0]        idx_next;
  logic signed [DATA_WIDTH-1:0] first_word;

  // A write may never touch the bank currently being delivered.
  assign wr_reject    = wrEnable && (({1'b0, wrBank} >= NUM_BANKS_W) ||
                                     ({1'b0, wrAddr} >= LENGTH_W) ||
                                     (busy && (wrBank == bank_reg)));
  assign wr_accept    = wrEnable && !wr_reject;
  assign start_accept = startLoad && (state_reg == IDLE) && ({1'b0, bankSelect} < NUM_BANKS_W);
  assign start_reject = startLoad && !start_accept;
  assign start_idx    = reverseOrder ? LAST_IDX : '0;
  assign idx_next     = rev_reg ? (idx_reg - ADDR_WIDTH'(1)) : (idx_reg + ADDR_WIDTH'(1));

  // A same-cycle write to the first word must be seen by the stream.
  assign first_word = (wr_accept && (wrBank == bankSelect) && (wrAddr == start_idx)) ?
                      wrData : mem_word[bankSelect][start_idx];

  for (genvar gi = 0; gi < BANK_SLOTS; gi++) begin : g_bank
    for (genvar gj = 0; gj < LENGTH; gj++) begin : g_word
      localparam logic signed [DATA_WIDTH-1:0] INIT = default_coef(gi, gj);
      logic signed [DATA_WIDTH-1:0] word_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          word_reg <= INIT;
        end else if (wr_accept && (wrBank == BANK_WIDTH'(gi)) && (wrAddr == ADDR_WIDTH'(gj))) begin
          word_reg <= wrData;
        end
      end

      assign mem_word[gi][gj] = word_reg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      bank_reg         <= '0;
      rev_reg          <= 1'b0;
      idx_reg          <= '0;
      count_reg        <= '0;
      coefficientOut   <= '0;
      coefficientValid <= 1'b0;
      busy             <= 1'b0;
      loadDone         <= 1'b0;
      filterSetFlag    <= 1'b0;
      errorFlag        <= 1'b0;
    end else begin
      errorFlag <= wr_reject || start_reject;
      loadDone  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_accept) begin
            bank_reg         <= bankSelect;
            rev_reg          <= reverseOrder;
            idx_reg          <= start_idx;
            count_reg        <= '0;
            coefficientOut   <= first_word;
            coefficientValid <= 1'b1;
            filterSetFlag    <= 1'b0;
            busy             <= 1'b1;
            state_reg        <= STREAM;
          end
        end
        STREAM: begin
          if (coefficientValid && coefficientReady) begin
            // The counter, not the index, ends the stream so the index never wraps.
            if (count_reg == LAST_COUNT) begin
              coefficientValid <= 1'b0;
              loadDone         <= 1'b1;
              filterSetFlag    <= 1'b1;
              state_reg        <= DONE;
            end else begin
              idx_reg        <= idx_next;
              count_reg      <= count_reg + (ADDR_WIDTH+1)'(1);
              coefficientOut <= mem_word[bank_reg][idx_next];
            end
          end
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
